// File: rtl/axis_data_to_axis_string.sv
// Converts each AXI-Stream beat (tdata/tdest/tuser) into an ASCII string:
// prefix, hex digits, delimiters and a terminator, one character per output beat.
module axis_data_to_axis_string #(
  parameter logic [7:0] DELIMITER   = ";",
  parameter logic [7:0] TERMINATION = "\n",
  parameter int         SBUS_WIDTH  = 1,
  parameter int         USER_WIDTH  = 4,
  parameter int         DEST_WIDTH  = 4,
  parameter logic [7:0] DATA_PREFIX = "#",
  parameter logic [7:0] DEST_PREFIX = "&",
  parameter logic [7:0] USER_PREFIX = "*"
) (
  input  logic                    aclk,
  input  logic                    arstn,
  input  logic [SBUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int DD = 2 * SBUS_WIDTH;
  localparam int ND = (DEST_WIDTH + 3) / 4;
  localparam int NU = (USER_WIDTH + 3) / 4;

  typedef enum logic [3:0] {
    IDLE, DATA_PFX, DATA_HEX, DLM1, DEST_PFX, DEST_HEX, DLM2, USER_PFX, USER_HEX, TERM
  } state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic [SBUS_WIDTH*8-1:0] data_reg, data_next;
  logic [DEST_WIDTH-1:0]   dest_reg, dest_next;
  logic [USER_WIDTH-1:0]   user_reg, user_next;
  logic [7:0]              m_tdata_reg, m_tdata_next;
  logic                    m_tvalid_reg, m_tvalid_next;
  logic                    s_tready_reg, s_tready_next;

  logic                    s_hs, m_hs;
  logic [63:0]             data_ext, dest_ext, user_ext;
  logic [7:0]              data_hex [16];
  logic [7:0]              dest_hex [16];
  logic [7:0]              user_hex [16];

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Zero-extending to 64 bits pads partial nibbles at the MSB end.
  assign data_ext = 64'(data_reg);
  assign dest_ext = 64'(dest_reg);
  assign user_ext = 64'(user_reg);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_hex
      assign data_hex[gi] = hex_char(data_ext[gi*4 +: 4]);
      assign dest_hex[gi] = hex_char(dest_ext[gi*4 +: 4]);
      assign user_hex[gi] = hex_char(user_ext[gi*4 +: 4]);
    end
  endgenerate

  assign s_hs = s_axis_tvalid & s_tready_reg;
  assign m_hs = m_tvalid_reg & m_axis_tready;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    data_next     = data_reg;
    dest_next     = dest_reg;
    user_next     = user_reg;
    m_tdata_next  = m_tdata_reg;
    m_tvalid_next = m_tvalid_reg;
    case (state_reg)
      IDLE: if (s_hs) begin
        data_next     = s_axis_tdata;
        dest_next     = s_axis_tdest;
        user_next     = s_axis_tuser;
        state_next    = DATA_PFX;
        m_tvalid_next = 1'b1;
        m_tdata_next  = DATA_PREFIX;
      end
      DATA_PFX: if (m_hs) begin
        state_next   = DATA_HEX;
        cnt_next     = 4'(DD - 1);
        m_tdata_next = data_hex[4'(DD - 1)];
      end
      DATA_HEX: if (m_hs) begin
        if (cnt_reg == 4'd0) begin
          state_next   = DLM1;
          m_tdata_next = DELIMITER;
        end else begin
          cnt_next     = cnt_reg - 4'd1;
          m_tdata_next = data_hex[cnt_reg - 4'd1];
        end
      end
      DLM1: if (m_hs) begin
        state_next   = DEST_PFX;
        m_tdata_next = DEST_PREFIX;
      end
      DEST_PFX: if (m_hs) begin
        state_next   = DEST_HEX;
        cnt_next     = 4'(ND - 1);
        m_tdata_next = dest_hex[4'(ND - 1)];
      end
      DEST_HEX: if (m_hs) begin
        if (cnt_reg == 4'd0) begin
          state_next   = DLM2;
          m_tdata_next = DELIMITER;
        end else begin
          cnt_next     = cnt_reg - 4'd1;
          m_tdata_next = dest_hex[cnt_reg - 4'd1];
        end
      end
      DLM2: if (m_hs) begin
        state_next   = USER_PFX;
        m_tdata_next = USER_PREFIX;
      end
      USER_PFX: if (m_hs) begin
        state_next   = USER_HEX;
        cnt_next     = 4'(NU - 1);
        m_tdata_next = user_hex[4'(NU - 1)];
      end
      USER_HEX: if (m_hs) begin
        if (cnt_reg == 4'd0) begin
          state_next   = TERM;
          m_tdata_next = TERMINATION;
        end else begin
          cnt_next     = cnt_reg - 4'd1;
          m_tdata_next = user_hex[cnt_reg - 4'd1];
        end
      end
      TERM: if (m_hs) begin
        state_next    = IDLE;
        m_tvalid_next = 1'b0;
      end
      default: begin
        state_next    = IDLE;
        m_tvalid_next = 1'b0;
      end
    endcase
    // Ready is registered, so it reflects the state being entered.
    s_tready_next = (state_next == IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      data_reg     <= '0;
      dest_reg     <= '0;
      user_reg     <= '0;
      m_tdata_reg  <= 8'h00;
      m_tvalid_reg <= 1'b0;
      s_tready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      data_reg     <= data_next;
      dest_reg     <= dest_next;
      user_reg     <= user_next;
      m_tdata_reg  <= m_tdata_next;
      m_tvalid_reg <= m_tvalid_next;
      s_tready_reg <= s_tready_next;
    end
  end

  assign s_axis_tready = s_tready_reg;
  assign m_axis_tdata  = m_tdata_reg;
  assign m_axis_tvalid = m_tvalid_reg;

endmodule

// File: tb/tb_axis_data_to_axis_string.sv
// Directed bench: default-parameter instance plus a wide/odd-width instance,
// each output string compared character by character against literal strings.
module tb_axis_data_to_axis_string;

  logic        aclk = 1'b0;
  logic        arstn;
  always #5 aclk = ~aclk;

  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready;
  logic [3:0]  s_tuser, s_tdest;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready;

  logic [15:0] s2_tdata;
  logic        s2_tvalid, s2_tready;
  logic [0:0]  s2_tuser;
  logic [4:0]  s2_tdest;
  logic [7:0]  m2_tdata;
  logic        m2_tvalid, m2_tready;

  int n_checks = 0;
  int n_pass   = 0;

  axis_data_to_axis_string dut (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tuser(s_tuser), .s_axis_tdest(s_tdest),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
  );

  axis_data_to_axis_string #(.SBUS_WIDTH(2), .DEST_WIDTH(5), .USER_WIDTH(1)) dut_w (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .s_axis_tuser(s2_tuser), .s_axis_tdest(s2_tdest),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Present one beat, then scramble the inputs to show they are not re-sampled.
  task automatic send_beat(input logic [7:0] d, input logic [3:0] dst, input logic [3:0] u);
    check("s_tready_before_beat", 32'(s_tready), 32'd1);
    s_tdata  = d;
    s_tdest  = dst;
    s_tuser  = u;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tdata  = 8'($urandom);
    s_tdest  = 4'($urandom);
    s_tuser  = 4'($urandom);
    $display("beat sent data=%02h dest=%0h user=%0h", d, dst, u);
  endtask

  task automatic expect_string(input string tag, input string s, input bit bp, input bit use2);
    int   idx = 0;
    int   cyc = 0;
    logic rdy;
    logic vld;
    logic sr;
    logic [7:0] dat;
    while (idx < s.len() && cyc < 200) begin
      rdy = (!bp) || (cyc % 2 == 0);
      if (use2) m2_tready = rdy;
      else      m_tready  = rdy;
      vld = use2 ? m2_tvalid : m_tvalid;
      dat = use2 ? m2_tdata  : m_tdata;
      sr  = use2 ? s2_tready : s_tready;
      check($sformatf("%s_valid_%0d", tag, idx), 32'(vld), 32'd1);
      check($sformatf("%s_char_%0d", tag, idx), 32'(dat), 32'(s[idx]));
      check($sformatf("%s_s_tready_busy_%0d", tag, idx), 32'(sr), 32'd0);
      tick();
      if (rdy) idx++;
      cyc++;
    end
    check($sformatf("%s_complete", tag), 32'(idx), 32'(s.len()));
    m_tready  = 1'b1;
    m2_tready = 1'b1;
    vld = use2 ? m2_tvalid : m_tvalid;
    sr  = use2 ? s2_tready : s_tready;
    check($sformatf("%s_idle_m_tvalid", tag), 32'(vld), 32'd0);
    check($sformatf("%s_idle_s_tready", tag), 32'(sr), 32'd1);
    $display("string %s done: %0d chars in %0d cycles", tag, idx, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn     = 1'b0;
    s_tdata   = '0; s_tdest = '0; s_tuser = '0;
    s_tvalid  = 1'b1;
    s2_tdata  = '0; s2_tdest = '0; s2_tuser = '0;
    s2_tvalid = 1'b0;
    m_tready  = 1'b1;
    m2_tready = 1'b1;
    tick(); tick(); tick();
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'h00);
    check("rst_w_s_tready", 32'(s2_tready), 32'd0);
    s_tvalid = 1'b0;
    arstn    = 1'b1;
    tick();
    check("release_s_tready", 32'(s_tready), 32'd1);
    check("release_m_tvalid", 32'(m_tvalid), 32'd0);
    check("release_w_s_tready", 32'(s2_tready), 32'd1);

    send_beat(8'hA5, 4'h3, 4'hC);
    expect_string("basic", "#A5;&3;*C\n", 1'b0, 1'b0);

    send_beat(8'hA5, 4'h3, 4'hC);
    expect_string("bp", "#A5;&3;*C\n", 1'b1, 1'b0);

    send_beat(8'h09, 4'h0, 4'hF);
    expect_string("b2b_1", "#09;&0;*F\n", 1'b0, 1'b0);
    send_beat(8'hFA, 4'hA, 4'h9);
    expect_string("b2b_2", "#FA;&A;*9\n", 1'b0, 1'b0);

    check("w_s_tready", 32'(s2_tready), 32'd1);
    s2_tdata  = 16'h00FF;
    s2_tdest  = 5'h1F;
    s2_tuser  = 1'b1;
    s2_tvalid = 1'b1;
    tick();
    s2_tvalid = 1'b0;
    s2_tdata  = 16'h1234;
    $display("beat sent to wide instance data=00FF dest=1F user=1");
    expect_string("width", "#00FF;&1F;*1\n", 1'b0, 1'b1);

    send_beat(8'h77, 4'h4, 4'h5);
    check("mid_char_0", 32'(m_tdata), 32'h23);
    tick(); tick(); tick(); tick();
    check("mid_char_4", 32'(m_tdata), 32'h26);
    arstn = 1'b0;
    tick();
    check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_rst_s_tready", 32'(s_tready), 32'd0);
    check("mid_rst_m_tdata", 32'(m_tdata), 32'h00);
    arstn = 1'b1;
    tick();
    check("mid_release_s_tready", 32'(s_tready), 32'd1);
    check("mid_release_m_tvalid", 32'(m_tvalid), 32'd0);
    send_beat(8'h5A, 4'h1, 4'h2);
    expect_string("after_rst", "#5A;&1;*2\n", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
